// File: rtl/adc_spi_responder_pkg.sv
// Shared constants, types and helpers for the ADC serial link (responder and master).
package adc_spi_responder_pkg;

    localparam int unsigned ADC_FRAME_BITS = 16;
    localparam int unsigned ADC_DATA_W     = 12;
    localparam int unsigned ADC_LEAD_ZEROS = 4;
    localparam int unsigned ADC_ADDR_MSB   = 13;
    localparam int unsigned ADC_ADDR_LSB   = 11;
    localparam int unsigned ADC_ADDR_W     = ADC_ADDR_MSB - ADC_ADDR_LSB + 1;
    localparam int unsigned ADC_CNT_W      = $clog2(ADC_FRAME_BITS + 1);
    localparam int unsigned ADC_IDX_W      = $clog2(ADC_FRAME_BITS);

    typedef logic [ADC_DATA_W-1:0] adc_sample_t;
    typedef logic [ADC_ADDR_W-1:0] adc_addr_t;

    // Serial response word, transmitted MSB first
    typedef struct packed {
        logic [ADC_LEAD_ZEROS-1:0] lead;
        adc_sample_t               sample;
    } adc_frame_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } adc_rsp_state_t;

    // Build the response word for one sample: leading zeros then the sample
    function automatic adc_frame_t adc_make_frame(input adc_sample_t sample);
        adc_frame_t frame;
        frame.lead   = '0;
        frame.sample = sample;
        return frame;
    endfunction

endpackage

// File: rtl/adc_spi_responder_if.sv
// Serial pins between the ADC master and the emulated converter.
interface adc_spi_responder_if;

    logic ADC_CS;
    logic ADC_clk;
    logic ADC_Din;
    logic ADC_Dout;

    modport master (
        output ADC_CS,
        output ADC_clk,
        output ADC_Din,
        input  ADC_Dout
    );

    modport slave (
        input  ADC_CS,
        input  ADC_clk,
        input  ADC_Din,
        output ADC_Dout
    );

endinterface

// File: rtl/adc_spi_responder_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with rise/fall pulses on the synced copy.
module adc_spi_responder_sync_edge #(
    parameter int unsigned SYNC_LEN = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_LEN-1:0] sync_q;
    logic                prev_q;

    // Synchronizer chain plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_LEN-2:0], pin};
            prev_q <= sync_q[SYNC_LEN-1];
        end
    end

    assign rise_c = sync_q[SYNC_LEN-1] & ~prev_q;
    assign fall_c = ~sync_q[SYNC_LEN-1] & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// Emulated 8-channel 12-bit SPI ADC: receives the channel address on ADC_Din and
// returns {4'b0, sample} MSB first on ADC_Dout, one frame of address pipelining.
module adc_spi_responder
    import adc_spi_responder_pkg::*;
#(
    parameter int unsigned N_CH     = 8,
    parameter int unsigned SYNC_LEN = 2
) (
    input  logic                clk,
    input  logic                reset,
    adc_spi_responder_if.slave  bus,
    input  adc_sample_t         ADC_DATA [N_CH-1:0],
    output logic                frame_done,
    output adc_addr_t           frame_addr
);

    // Only the bits up to and including the address field need to be kept
    localparam int unsigned RX_W = ADC_ADDR_MSB;
    localparam logic [ADC_CNT_W-1:0] FRAME_END = ADC_CNT_W'(ADC_FRAME_BITS);
    localparam logic [ADC_CNT_W-1:0] LAST_IDX  = ADC_CNT_W'(ADC_FRAME_BITS - 1);
    localparam logic [7:0] CH_VALID = 8'((64'd1 << N_CH) - 64'd1);

    logic cs_rise_c;
    logic cs_fall_c;
    logic sclk_rise_c;
    logic sclk_fall_c;
    logic din_s;

    logic [SYNC_LEN-1:0]       din_sync_q;
    adc_rsp_state_t            state_q;
    logic [ADC_FRAME_BITS-1:0] tx_shreg;
    logic [RX_W-1:0]           rx_shreg;
    logic [ADC_CNT_W-1:0]      bit_cnt;
    adc_addr_t                 next_ch;
    logic                      dout_q;

    adc_frame_t             load_frame_c;
    adc_addr_t              rx_addr_c;
    logic [ADC_IDX_W-1:0]   tx_idx_c;

    adc_spi_responder_sync_edge #(.SYNC_LEN(SYNC_LEN)) u_cs_sync (
        .clk    (clk),
        .rst_n  (reset),
        .pin    (bus.ADC_CS),
        .rise_c (cs_rise_c),
        .fall_c (cs_fall_c)
    );

    adc_spi_responder_sync_edge #(.SYNC_LEN(SYNC_LEN)) u_sclk_sync (
        .clk    (clk),
        .rst_n  (reset),
        .pin    (bus.ADC_clk),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_c)
    );

    // Data-in only needs the level, aligned with the clock synchronizer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            din_sync_q <= '0;
        end else begin
            din_sync_q <= {din_sync_q[SYNC_LEN-2:0], bus.ADC_Din};
        end
    end

    assign din_s        = din_sync_q[SYNC_LEN-1];
    assign load_frame_c = adc_make_frame(ADC_DATA[next_ch]);
    // Before the 16th bit shifts in, the address sits in the top of the 13 kept bits
    assign rx_addr_c    = rx_shreg[RX_W-1 -: ADC_ADDR_W];
    assign tx_idx_c     = ADC_IDX_W'(LAST_IDX - bit_cnt);
    assign bus.ADC_Dout = dout_q;

    // Frame FSM: CS rise aborts from any state; clock edges only matter in SHIFT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tx_shreg   <= '0;
            rx_shreg   <= '0;
            bit_cnt    <= '0;
            next_ch    <= '0;
            dout_q     <= 1'b0;
            frame_done <= 1'b0;
            frame_addr <= '0;
        end else begin
            frame_done <= 1'b0;
            if (cs_rise_c) begin
                state_q <= IDLE;
                dout_q  <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        dout_q  <= 1'b0;
                        bit_cnt <= '0;
                        if (cs_fall_c) begin
                            state_q <= LOAD;
                        end
                    end
                    LOAD: begin
                        tx_shreg <= load_frame_c;
                        bit_cnt  <= '0;
                        dout_q   <= load_frame_c[ADC_FRAME_BITS-1];
                        state_q  <= SHIFT;
                    end
                    SHIFT: begin
                        if (sclk_rise_c) begin
                            // Count saturates at a full frame; extra rises are ignored
                            if (bit_cnt != FRAME_END) begin
                                rx_shreg <= {rx_shreg[RX_W-2:0], din_s};
                                bit_cnt  <= bit_cnt + ADC_CNT_W'(1);
                                if (bit_cnt == LAST_IDX) begin
                                    frame_done <= 1'b1;
                                    frame_addr <= rx_addr_c;
                                    next_ch    <= CH_VALID[rx_addr_c] ? rx_addr_c : '0;
                                end
                            end
                        end else if (sclk_fall_c) begin
                            // Fall after a full frame with CS still low starts the next one
                            if (bit_cnt == FRAME_END) begin
                                state_q <= LOAD;
                            end else if (bit_cnt != '0) begin
                                dout_q <= tx_shreg[tx_idx_c];
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        dout_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench: drives the serial link as the master would at ADC_clk = clk/8.
module tb_adc_spi_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] adc_data [7:0];
    logic        frame_done;
    logic [2:0]  frame_addr;
    int          checks;
    int          failures;
    int          done_cnt;

    adc_spi_responder_if bus ();

    adc_spi_responder #(.N_CH(8), .SYNC_LEN(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .ADC_DATA   (adc_data),
        .frame_done (frame_done),
        .frame_addr (frame_addr)
    );

    always #5 clk = ~clk;

    // Count clock cycles with frame_done high
    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master frame: ev_kind 1 = change ADC_DATA[0] to ev_val, 2 = reset pulse, before bit ev_bit
    task automatic run_frame(input logic [15:0] word, input int nbits, input bit start_cs,
                             input bit end_cs, input int ev_bit, input int ev_kind,
                             input logic [11:0] ev_val, output logic [15:0] rx);
        rx = '0;
        if (start_cs) begin
            bus.ADC_CS = 1'b0;
            wait_clks(4);
        end
        for (int i = 0; i < nbits; i++) begin
            if (i == ev_bit) begin
                if (ev_kind == 1) begin
                    adc_data[0] = ev_val;
                end else if (ev_kind == 2) begin
                    reset = 1'b0;
                    wait_clks(2);
                    reset = 1'b1;
                end
            end
            bus.ADC_clk = 1'b0;
            bus.ADC_Din = word[15-i];
            wait_clks(4);
            rx[15-i] = bus.ADC_Dout;
            bus.ADC_clk = 1'b1;
            wait_clks(4);
        end
        if (end_cs) begin
            bus.ADC_CS = 1'b1;
            wait_clks(8);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wait_clks(3);
        checks++;
        if (bus.ADC_Dout !== 1'b0) begin
            failures++;
            $display("FAIL reset_dout got=%b want=0", bus.ADC_Dout);
        end
        checks++;
        if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_frame_done got=%b want=0", frame_done);
        end
        checks++;
        if (frame_addr !== 3'd0) begin
            failures++;
            $display("FAIL reset_frame_addr got=%0d want=0", frame_addr);
        end
        reset = 1'b1;
        wait_clks(8);
    endtask

    task automatic test_single_frame(input string tag);
        logic [15:0] rx;
        int          d0;
        adc_data[0] = 12'habc;
        d0 = done_cnt;
        run_frame(16'h0000, 16, 1'b1, 1'b1, -1, 0, 12'h0, rx);
        checks++;
        if (rx !== 16'h0abc) begin
            failures++;
            $display("FAIL %s_data got=%h want=0abc", tag, rx);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL %s_done_pulses got=%0d want=1", tag, done_cnt - d0);
        end
        checks++;
        if (frame_addr !== 3'd0) begin
            failures++;
            $display("FAIL %s_addr got=%0d want=0", tag, frame_addr);
        end
    endtask

    task automatic test_addr_pipeline();
        logic [15:0] rx;
        adc_data[3] = 12'h234;
        run_frame(16'h1800, 16, 1'b1, 1'b1, -1, 0, 12'h0, rx);
        checks++;
        if (rx !== 16'h0abc) begin
            failures++;
            $display("FAIL pipe_first_data got=%h want=0abc", rx);
        end
        checks++;
        if (frame_addr !== 3'd3) begin
            failures++;
            $display("FAIL pipe_first_addr got=%0d want=3", frame_addr);
        end
        run_frame(16'h0000, 16, 1'b1, 1'b1, -1, 0, 12'h0, rx);
        checks++;
        if (rx !== 16'h0234) begin
            failures++;
            $display("FAIL pipe_second_data got=%h want=0234", rx);
        end
        checks++;
        if (frame_addr !== 3'd0) begin
            failures++;
            $display("FAIL pipe_second_addr got=%0d want=0", frame_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3];
        logic [15:0] want [3];
        logic [2:0]  want_addr [3];
        logic [15:0] rx;
        int          d0;
        words = '{16'h0800, 16'h1000, 16'h0000};
        want = '{16'h0333, 16'h0111, 16'h0222};
        want_addr = '{3'd1, 3'd2, 3'd0};
        adc_data[0] = 12'h333;
        adc_data[1] = 12'h111;
        adc_data[2] = 12'h222;
        d0 = done_cnt;
        bus.ADC_CS = 1'b0;
        wait_clks(4);
        for (int f = 0; f < 3; f++) begin
            run_frame(words[f], 16, 1'b0, 1'b0, -1, 0, 12'h0, rx);
            checks++;
            if (rx !== want[f]) begin
                failures++;
                $display("FAIL b2b_data%0d got=%h want=%h", f, rx, want[f]);
            end
            checks++;
            if (frame_addr !== want_addr[f]) begin
                failures++;
                $display("FAIL b2b_addr%0d got=%0d want=%0d", f, frame_addr, want_addr[f]);
            end
        end
        bus.ADC_CS = 1'b1;
        wait_clks(8);
        checks++;
        if (done_cnt - d0 != 3) begin
            failures++;
            $display("FAIL b2b_done_pulses got=%0d want=3", done_cnt - d0);
        end
    endtask

    task automatic test_abort();
        logic [15:0] rx;
        int          d0;
        adc_data[5] = 12'h5a5;
        d0 = done_cnt;
        run_frame(16'h2800, 8, 1'b1, 1'b0, -1, 0, 12'h0, rx);
        checks++;
        if (rx[15:8] !== 8'h03) begin
            failures++;
            $display("FAIL abort_partial got=%h want=03", rx[15:8]);
        end
        bus.ADC_CS = 1'b1;
        wait_clks(8);
        checks++;
        if (bus.ADC_Dout !== 1'b0) begin
            failures++;
            $display("FAIL abort_dout got=%b want=0", bus.ADC_Dout);
        end
        checks++;
        if (done_cnt - d0 != 0) begin
            failures++;
            $display("FAIL abort_done_pulses got=%0d want=0", done_cnt - d0);
        end
        checks++;
        if (frame_addr !== 3'd0) begin
            failures++;
            $display("FAIL abort_addr got=%0d want=0", frame_addr);
        end
        run_frame(16'h0000, 16, 1'b1, 1'b1, -1, 0, 12'h0, rx);
        checks++;
        if (rx !== 16'h0333) begin
            failures++;
            $display("FAIL abort_next_data got=%h want=0333", rx);
        end
    endtask

    task automatic test_data_change();
        logic [15:0] rx;
        adc_data[0] = 12'habc;
        run_frame(16'h0000, 16, 1'b1, 1'b1, 6, 1, 12'h555, rx);
        checks++;
        if (rx !== 16'h0abc) begin
            failures++;
            $display("FAIL change_cur_data got=%h want=0abc", rx);
        end
        run_frame(16'h1800, 16, 1'b1, 1'b1, -1, 0, 12'h0, rx);
        checks++;
        if (rx !== 16'h0555) begin
            failures++;
            $display("FAIL change_next_data got=%h want=0555", rx);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] rx;
        int          d0;
        d0 = done_cnt;
        run_frame(16'h0000, 16, 1'b1, 1'b0, 9, 2, 12'h0, rx);
        checks++;
        if (rx[6:0] !== 7'h00) begin
            failures++;
            $display("FAIL rstmid_tail got=%h want=00", rx[6:0]);
        end
        checks++;
        if (bus.ADC_Dout !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_dout got=%b want=0", bus.ADC_Dout);
        end
        checks++;
        if (frame_addr !== 3'd0) begin
            failures++;
            $display("FAIL rstmid_addr got=%0d want=0", frame_addr);
        end
        checks++;
        if (done_cnt - d0 != 0) begin
            failures++;
            $display("FAIL rstmid_done_pulses got=%0d want=0", done_cnt - d0);
        end
        bus.ADC_CS = 1'b1;
        wait_clks(8);
        run_frame(16'h0000, 16, 1'b1, 1'b1, -1, 0, 12'h0, rx);
        checks++;
        if (rx !== 16'h0555) begin
            failures++;
            $display("FAIL rstmid_next_data got=%h want=0555", rx);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        done_cnt    = 0;
        bus.ADC_CS  = 1'b1;
        bus.ADC_clk = 1'b1;
        bus.ADC_Din = 1'b0;
        for (int i = 0; i < 8; i++) adc_data[i] = 12'h000;
        test_reset();
        test_single_frame("single");
        test_addr_pipeline();
        test_back_to_back();
        test_abort();
        test_data_change();
        test_reset_mid_frame();
        test_single_frame("repeat");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
